// File: rtl/qspi_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : qspi_mem_responder_if
// Brief    : Quad-SPI pin bundle between a controller and the memory responder.
// Revision : 1.0 - initial release
// ============================================================================
interface qspi_mem_responder_if;
    logic       spi_clk_in;
    logic       spi_select_n_in;
    logic [3:0] spi_data_in;
    logic [3:0] spi_data_out;
    logic [3:0] spi_data_oe;
    logic       busy;

    modport master (
        output spi_clk_in,
        output spi_select_n_in,
        output spi_data_in,
        input  spi_data_out,
        input  spi_data_oe,
        input  busy
    );

    modport slave (
        input  spi_clk_in,
        input  spi_select_n_in,
        input  spi_data_in,
        output spi_data_out,
        output spi_data_oe,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/qspi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : qspi_mem_responder
// Brief    : Oversampled Quad-SPI RAM emulator (quad write 0x38, quad read 0xEB).
// Revision : 1.0 - initial release
// ============================================================================
module qspi_mem_responder #(
    parameter int         ADDR_BITS    = 6,
    parameter int         DUMMY_CYCLES = 6,
    parameter logic [7:0] CMD_READ     = 8'hEB,
    parameter logic [7:0] CMD_WRITE    = 8'h38
) (
    input wire logic            clock,
    input wire logic            reset,
    qspi_mem_responder_if.slave bus
);
    localparam int c_DEPTH   = 1 << ADDR_BITS;
    // Stored shift bits: 4 for the opcode high nibble, enough for the address otherwise.
    localparam int c_SH_W    = (ADDR_BITS - 4 > 4) ? ADDR_BITS - 4 : 4;
    localparam int c_DUMMY_W = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
    localparam logic [c_DUMMY_W-1:0] c_DUMMY_LAST =
        c_DUMMY_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CMD    = 3'd1;
    localparam logic [2:0] c_ADDR   = 3'd2;
    localparam logic [2:0] c_DUMMY  = 3'd3;
    localparam logic [2:0] c_READ   = 3'd4;
    localparam logic [2:0] c_WRITE  = 3'd5;
    localparam logic [2:0] c_IGNORE = 3'd6;

    logic [2:0]           r_sck_s;
    logic [2:0]           r_csn_s;
    logic [3:0]           r_io_s1;
    logic [3:0]           r_io_s2;
    logic [2:0]           r_state;
    logic [2:0]           r_nib_cnt;
    logic [c_DUMMY_W-1:0] r_dummy_cnt;
    logic [c_SH_W-1:0]    r_shift;
    logic                 r_is_read;
    logic                 r_half;
    logic [3:0]           r_wr_hi;
    logic [ADDR_BITS-1:0] r_addr;
    logic [3:0]           r_data_out;
    logic [3:0]           r_oe;
    logic [7:0]           r_mem [c_DEPTH];

    logic                 w_sck_rise;
    logic                 w_sck_fall;
    logic                 w_cs_high;
    logic                 w_cs_fall;
    logic [c_SH_W+3:0]    w_shift_next;
    logic [7:0]           w_rd_byte;

    // Stage 1 of r_sck_s/r_csn_s is the first synchroniser flop, stage 2 the
    // synchronised copy, stage 3 the delayed copy used for edge detection.
    assign w_sck_rise   = r_sck_s[1] & ~r_sck_s[2];
    assign w_sck_fall   = ~r_sck_s[1] & r_sck_s[2];
    assign w_cs_high    = r_csn_s[1];
    assign w_cs_fall    = ~r_csn_s[1] & r_csn_s[2];
    assign w_shift_next = {r_shift, r_io_s2};
    assign w_rd_byte    = r_mem[r_addr];

    assign bus.spi_data_out = r_data_out;
    assign bus.spi_data_oe  = r_oe;
    assign bus.busy         = (r_state != c_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            // CS synchronisers clear low so a fresh high-then-low is needed after reset.
            r_sck_s     <= '0;
            r_csn_s     <= '0;
            r_io_s1     <= '0;
            r_io_s2     <= '0;
            r_state     <= c_IDLE;
            r_nib_cnt   <= '0;
            r_dummy_cnt <= '0;
            r_shift     <= '0;
            r_is_read   <= 1'b0;
            r_half      <= 1'b0;
            r_wr_hi     <= '0;
            r_addr      <= '0;
            r_data_out  <= '0;
            r_oe        <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_sck_s <= {r_sck_s[1:0], bus.spi_clk_in};
            r_csn_s <= {r_csn_s[1:0], bus.spi_select_n_in};
            r_io_s1 <= bus.spi_data_in;
            r_io_s2 <= r_io_s1;

            if (r_state != c_IDLE && w_cs_high) begin
                r_state   <= c_IDLE;
                r_oe      <= '0;
                r_half    <= 1'b0;
                r_nib_cnt <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= c_CMD;
                            r_nib_cnt <= '0;
                        end
                    end
                    c_CMD: begin
                        if (w_sck_rise) begin
                            r_shift   <= w_shift_next[c_SH_W-1:0];
                            r_nib_cnt <= r_nib_cnt + 1'b1;
                            if (r_nib_cnt == 3'd1) begin
                                r_nib_cnt <= '0;
                                if (w_shift_next[7:0] == CMD_READ) begin
                                    r_is_read <= 1'b1;
                                    r_state   <= c_ADDR;
                                end else if (w_shift_next[7:0] == CMD_WRITE) begin
                                    r_is_read <= 1'b0;
                                    r_state   <= c_ADDR;
                                end else begin
                                    r_state   <= c_IGNORE;
                                end
                            end
                        end
                    end
                    c_ADDR: begin
                        if (w_sck_rise) begin
                            r_shift   <= w_shift_next[c_SH_W-1:0];
                            r_nib_cnt <= r_nib_cnt + 1'b1;
                            if (r_nib_cnt == 3'd5) begin
                                r_nib_cnt   <= '0;
                                r_addr      <= w_shift_next[ADDR_BITS-1:0];
                                r_half      <= 1'b0;
                                r_dummy_cnt <= '0;
                                if (!r_is_read) begin
                                    r_state <= c_WRITE;
                                end else if (DUMMY_CYCLES == 0) begin
                                    r_state <= c_READ;
                                end else begin
                                    r_state <= c_DUMMY;
                                end
                            end
                        end
                    end
                    c_DUMMY: begin
                        if (w_sck_rise) begin
                            if (r_dummy_cnt == c_DUMMY_LAST) begin
                                r_state <= c_READ;
                            end else begin
                                r_dummy_cnt <= r_dummy_cnt + 1'b1;
                            end
                        end
                    end
                    c_READ: begin
                        if (w_sck_fall) begin
                            r_oe <= 4'hF;
                            if (!r_half) begin
                                r_data_out <= w_rd_byte[7:4];
                                r_half     <= 1'b1;
                            end else begin
                                r_data_out <= w_rd_byte[3:0];
                                r_half     <= 1'b0;
                                r_addr     <= r_addr + 1'b1;
                            end
                        end
                    end
                    c_WRITE: begin
                        if (w_sck_rise) begin
                            if (!r_half) begin
                                r_wr_hi <= r_io_s2;
                                r_half  <= 1'b1;
                            end else begin
                                r_mem[r_addr] <= {r_wr_hi, r_io_s2};
                                r_half        <= 1'b0;
                                r_addr        <= r_addr + 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IGNORE and unused encodings wait here for CS high.
                    end
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_qspi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_qspi_mem_responder
// Brief    : Directed self-checking bench for the Quad-SPI memory responder.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_qspi_mem_responder;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    qspi_mem_responder_if bus ();

    qspi_mem_responder dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCK cycle: data set while low, rise, fall, then settle time for the output.
    task automatic pulse(input logic [3:0] nib);
        bus.spi_data_in = nib;
        #40 bus.spi_clk_in = 1'b1;
        #40 bus.spi_clk_in = 1'b0;
        #40;
    endtask

    task automatic send_byte(input logic [7:0] b);
        pulse(b[7:4]);
        pulse(b[3:0]);
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic cs_low();
        bus.spi_select_n_in = 1'b0;
        #80;
    endtask

    task automatic cs_high();
        bus.spi_select_n_in = 1'b1;
        #80;
    endtask

    task automatic write_bytes(input logic [23:0] a, input int n, input logic [31:0] data);
        cs_low();
        send_byte(8'h38);
        send_addr(a);
        for (int i = 0; i < n; i++) send_byte(data[31-8*i -: 8]);
        cs_high();
    endtask

    // Expected bytes are packed MSB-first in 'data'.
    task automatic read_bytes(input string tag, input logic [23:0] a, input int n,
                              input logic [31:0] data);
        cs_low();
        send_byte(8'hEB);
        send_addr(a);
        repeat (6) pulse(4'h0);
        for (int i = 0; i < 2 * n; i++) begin
            if (i > 0) pulse(4'h0);
            check({tag, "_oe"}, 32'(bus.spi_data_oe), 32'hF);
            check({tag, "_nib"}, 32'(bus.spi_data_out), 32'(data[31-4*i -: 4]));
        end
        cs_high();
        check({tag, "_oe_after"}, 32'(bus.spi_data_oe), 32'h0);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        bus.spi_clk_in      = 1'b0;
        bus.spi_select_n_in = 1'b1;
        bus.spi_data_in     = 4'h0;
        repeat (3) @(posedge clock);
        #2;
        check("rst_out", 32'(bus.spi_data_out), 32'h0);
        check("rst_oe", 32'(bus.spi_data_oe), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_mem", 32'(dut.r_mem[16]), 32'h0);
        reset = 1'b0;
        #40;

        // Write then read back two bytes
        write_bytes(24'h000010, 2, 32'hA53C_0000);
        check("wr_mem10", 32'(dut.r_mem[16]), 32'hA5);
        check("wr_mem11", 32'(dut.r_mem[17]), 32'h3C);
        read_bytes("rd10", 24'h000010, 2, 32'hA53C_0000);

        // Wrap-around at the top of the array
        write_bytes(24'h00003F, 2, 32'h1122_0000);
        check("wrap_mem3f", 32'(dut.r_mem[63]), 32'h11);
        check("wrap_mem00", 32'(dut.r_mem[0]), 32'h22);
        read_bytes("rdwrap", 24'h00003F, 2, 32'h1122_0000);

        // Unknown opcode is ignored until CS rises
        cs_low();
        send_byte(8'h9F);
        for (int i = 0; i < 8; i++) begin
            pulse(4'(i + 3));
            check("unk_oe", 32'(bus.spi_data_oe), 32'h0);
            check("unk_busy", 32'(bus.busy), 32'h1);
        end
        bus.spi_select_n_in = 1'b1;
        #30;
        check("unk_busy_cs", 32'(bus.busy), 32'h0);
        #50;
        check("unk_mem10", 32'(dut.r_mem[16]), 32'hA5);
        check("unk_mem00", 32'(dut.r_mem[0]), 32'h22);

        // Abort mid-byte: the trailing single nibble is discarded
        cs_low();
        send_byte(8'h38);
        send_addr(24'h000005);
        pulse(4'h7);
        pulse(4'hE);
        pulse(4'h4);
        bus.spi_select_n_in = 1'b1;
        #30;
        check("abort_oe", 32'(bus.spi_data_oe), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        #50;
        check("abort_mem05", 32'(dut.r_mem[5]), 32'h7E);
        check("abort_mem06", 32'(dut.r_mem[6]), 32'h00);

        // Address truncation to the array size
        write_bytes(24'hFFFF02, 1, 32'h5A00_0000);
        check("trunc_mem02", 32'(dut.r_mem[2]), 32'h5A);
        read_bytes("rdtrunc", 24'h000002, 1, 32'h5A00_0000);

        // Reset during the read data phase
        cs_low();
        send_byte(8'hEB);
        send_addr(24'h000010);
        repeat (6) pulse(4'h0);
        check("rstrd_nib", 32'(bus.spi_data_out), 32'hA);
        check("rstrd_oe", 32'(bus.spi_data_oe), 32'hF);
        reset = 1'b1;
        #10;
        reset = 1'b0;
        check("rstrd_oe0", 32'(bus.spi_data_oe), 32'h0);
        check("rstrd_busy0", 32'(bus.busy), 32'h0);
        check("rstrd_mem10", 32'(dut.r_mem[16]), 32'h00);
        check("rstrd_mem02", 32'(dut.r_mem[2]), 32'h00);
        for (int i = 0; i < 4; i++) begin
            pulse(4'hF);
            check("rstrd_idle_busy", 32'(bus.busy), 32'h0);
            check("rstrd_idle_oe", 32'(bus.spi_data_oe), 32'h0);
        end
        cs_high();

        // A fresh CS fall brings the responder back
        write_bytes(24'h000001, 1, 32'h9900_0000);
        check("post_rst_mem01", 32'(dut.r_mem[1]), 32'h99);
        check("post_rst_mem10", 32'(dut.r_mem[16]), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/qspi_mem_responder.md
Name: qspi_mem_responder

Overview:
- Quad-SPI target (responder): the other end of the CPU's QSPI controller interface.
- Emulates a small QSPI RAM so the CPU's quad read/write sequences can be exercised in simulation and on-chip loopback without external memory.
- Oversamples SCK/CS/IO on the system clock; holds a small internal byte array.
- Supports quad write (0x38) and quad fast read (0xEB) with dummy cycles.

Parameters:
ADDR_BITS, 6, internal memory is 2^ADDR_BITS bytes; received address is truncated to these low bits
DUMMY_CYCLES, 6, SCK rising edges between the last address nibble and the first read-data nibble
CMD_READ, 8'hEB, quad read opcode
CMD_WRITE, 8'h38, quad write opcode

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  synchronous, active-high reset
spi_clk_in  in  1  SCK from controller (async to clock)
spi_select_n_in  in  1  chip select, active low (async)
spi_data_in  in  4  IO[3:0] from controller (async)
spi_data_out  out  4  IO[3:0] driven by responder
spi_data_oe  out  4  per-line output enable, 1 = drive
busy  out  1  high while a transaction is in progress (state != IDLE)

Behaviour:
- Synchronisation: SCK, CS_n and IO pass through 2-flop synchronisers; edges are detected against a third registered copy of SCK. Requires f(clock) >= 4 x f(SCK). IO is sampled from the synchronised copy aligned with the SCK edge detect.
- Reset: spi_data_out=0, spi_data_oe=0, busy=0, state=IDLE, address/counters=0, all memory bytes=8'h00. Reset overrides everything, including mid-transaction; after reset, traffic is ignored until CS_n is seen high and then falls again.
- Protocol: all phases are 4-bit, MSB nibble first; data is sampled on SCK rise and driven on SCK fall.
- States: IDLE, CMD, ADDR, DUMMY, READ, WRITE, IGNORE.
  - IDLE: a synchronised CS_n falling edge moves to CMD; nibble counter=0.
  - CMD: 2 rising edges shift the opcode. After the 2nd nibble: CMD_READ or CMD_WRITE goes to ADDR; any other opcode goes to IGNORE.
  - ADDR: 6 rising edges shift a 24-bit address. After the 6th nibble, addr <= addr24[ADDR_BITS-1:0]; go to DUMMY (read) or WRITE (write).
  - DUMMY: count DUMMY_CYCLES rising edges, then go to READ. If DUMMY_CYCLES=0, go straight from ADDR to READ.
  - READ: on each SCK falling edge, drive the next nibble: high nibble of mem[addr], then low nibble, then addr <= addr+1. spi_data_oe=4'hF from the first READ falling edge until exit. spi_data_out changes <=3 clock cycles after the pin-level SCK fall.
  - WRITE: on each rising edge, capture a nibble. On the 2nd nibble, mem[addr] <= byte and addr <= addr+1.
  - IGNORE: no drive, no memory change; wait for CS_n high.
- Address wraps modulo 2^ADDR_BITS in both READ and WRITE; no error is flagged.
- CS_n synchronised high in any state: next cycle state=IDLE, spi_data_oe=0, busy=0. A partially received write byte (1 nibble) is discarded. An interrupted CMD/ADDR is dropped with no memory effect.
- CS_n rise and an SCK edge in the same clock cycle: CS wins; the edge is ignored.
- spi_data_oe is 0 in every state except READ; spi_data_out holds its last value when not driving.
- Only a single-cycle write port and a single read port to the array are needed per clock.

Test Plan:
- Write then read: CS low, 0x38, addr 0x000010, data A5 3C, CS high; then 0xEB, addr 0x000010, 6 dummy, 4 falling edges -> nibbles A,5,3,C driven with oe=F; mem[0x10]=A5, mem[0x11]=3C.
- Wrap-around: write 0x38 at addr 0x00003F with bytes 11 22 -> mem[0x3F]=11, mem[0x00]=22. Read 0xEB at 0x3F for 2 bytes -> 11 22.
- Unknown opcode: 0x9F followed by 8 SCK cycles -> oe stays 0 throughout; busy=1 until CS high, then 0; memory unchanged.
- Abort mid-byte: 0x38 at addr 0x05, data nibbles 7,E,4 then CS high -> mem[0x05]=7E, mem[0x06] unchanged (00); oe=0 and busy=0 within 3 clocks of CS rising.
- Reset mid-read: assert reset during the READ data phase -> next cycle oe=0, busy=0, mem reads back 00. Continuing SCK with CS still low has no effect until a new CS fall.
- Address truncation: write at addr 0xFFFF02 byte 5A, read at 0x000002 -> 5A.
